// File: rtl/fix_msg_sequencer.sv
// Sequences queued FIX tag/value fields through the byte serializer, accumulates the
// mod-256 checksum over every emitted byte and appends the 10=NNN trailer field.
module fix_msg_sequencer #(
    parameter int VALUE_WIDTH = 256,
    parameter int SIZE        = 5,
    parameter int MAX_FIELDS  = 16,
    parameter int AW          = 4,
    localparam int VW         = VALUE_WIDTH >> SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fld_wr_i,
    input  logic [31:0]            fld_tag_i,
    input  logic [4:0]             fld_t_size_i,
    input  logic [VALUE_WIDTH-1:0] fld_val_i,
    input  logic [VW-1:0]          fld_v_size_i,
    output logic                   fld_full_o,
    input  logic                   send_i,
    output logic                   busy_o,
    output logic                   msg_done_o,
    output logic                   tag_valid_o,
    output logic                   val_valid_o,
    output logic                   checksum_o,
    output logic [31:0]            tag_o,
    output logic [4:0]             t_size_o,
    output logic [VALUE_WIDTH-1:0] val_o,
    output logic [VW-1:0]          v_size_o,
    input  logic                   ser_done_i,
    input  logic [7:0]             ser_data_i,
    input  logic                   ser_data_valid_i,
    output logic [7:0]             cksum_o
);

    localparam int EW = 32 + 5 + VALUE_WIDTH + VW;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TAG, S_VAL, S_CALC, S_CK_TAG, S_CK_VAL, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [EW-1:0]          mem_q [MAX_FIELDS];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q, count_d;
    logic [31:0]            tag_q, tag_d;
    logic [4:0]             t_size_q, t_size_d;
    logic [VALUE_WIDTH-1:0] val_q, val_d;
    logic [VW-1:0]          v_size_q, v_size_d;
    logic [7:0]             acc_q, acc_d, acc_add_s;
    logic [7:0]             cksum_q, cksum_d;
    logic                   checksum_q, checksum_d;
    logic                   wr_en_s, pop_s;
    logic [7:0]             dig_h_s, dig_t_s, dig_u_s;

    assign busy_o      = (state_q != S_IDLE);
    assign fld_full_o  = (count_q == (AW+1)'(MAX_FIELDS)) | busy_o;
    assign wr_en_s     = fld_wr_i & ~fld_full_o;
    assign tag_valid_o = (state_q == S_TAG) | (state_q == S_CK_TAG);
    assign val_valid_o = (state_q == S_VAL) | (state_q == S_CK_VAL);
    assign msg_done_o  = (state_q == S_DONE);
    assign checksum_o  = checksum_q;
    assign tag_o       = tag_q;
    assign t_size_o    = t_size_q;
    assign val_o       = val_q;
    assign v_size_o    = v_size_q;
    assign cksum_o     = cksum_q;

    assign acc_add_s = acc_q + (ser_data_valid_i ? ser_data_i : 8'd0);
    assign dig_h_s   = acc_q / 8'd100;
    assign dig_t_s   = (acc_q % 8'd100) / 8'd10;
    assign dig_u_s   = acc_q % 8'd10;

    // Field storage; pointers are reset separately so stale entries are never read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {fld_tag_i, fld_t_size_i, fld_val_i, fld_v_size_i};
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        t_size_d   = t_size_q;
        val_d      = val_q;
        v_size_d   = v_size_q;
        acc_d      = acc_q;
        cksum_d    = cksum_q;
        checksum_d = checksum_q;
        pop_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send_i && (count_q != '0)) begin
                    state_d = S_LOAD;
                    acc_d   = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                {tag_d, t_size_d, val_d, v_size_d} = mem_q[rd_ptr_q];
                pop_s   = 1'b1;
                acc_d   = acc_add_s;
                state_d = S_TAG;
            end
            S_TAG: begin
                acc_d = acc_add_s;
                if (ser_done_i) begin
                    state_d = S_VAL;
                end else begin
                    state_d = S_TAG;
                end
            end
            S_VAL: begin
                acc_d = acc_add_s;
                // Writes are refused while busy, so count_q is exactly the fields still to send.
                if (ser_done_i) begin
                    state_d = (count_q != '0) ? S_LOAD : S_CALC;
                end else begin
                    state_d = S_VAL;
                end
            end
            S_CALC: begin
                cksum_d     = acc_q;
                tag_d       = 32'h0000_3031;
                t_size_d    = 5'd2;
                val_d       = '0;
                val_d[23:0] = {8'h30 + dig_u_s, 8'h30 + dig_t_s, 8'h30 + dig_h_s};
                v_size_d    = VW'(3);
                checksum_d  = 1'b1;
                state_d     = S_CK_TAG;
            end
            S_CK_TAG: begin
                if (ser_done_i) begin
                    state_d = S_CK_VAL;
                end else begin
                    state_d = S_CK_TAG;
                end
            end
            S_CK_VAL: begin
                if (ser_done_i) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CK_VAL;
                end
            end
            S_DONE: begin
                checksum_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign count_d = count_q + {{AW{1'b0}}, wr_en_s} - {{AW{1'b0}}, pop_s};

    // State, queue pointers and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tag_q      <= '0;
            t_size_q   <= '0;
            val_q      <= '0;
            v_size_q   <= '0;
            acc_q      <= '0;
            cksum_q    <= '0;
            checksum_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_q + AW'(wr_en_s);
            rd_ptr_q   <= rd_ptr_q + AW'(pop_s);
            count_q    <= count_d;
            tag_q      <= tag_d;
            t_size_q   <= t_size_d;
            val_q      <= val_d;
            v_size_q   <= v_size_d;
            acc_q      <= acc_d;
            cksum_q    <= cksum_d;
            checksum_q <= checksum_d;
        end
    end

endmodule

// File: tb/tb_fix_msg_sequencer.sv
// Directed bench for fix_msg_sequencer with a behavioural byte serializer driven from tasks.
module tb_fix_msg_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         fld_wr_i;
    logic [31:0]  fld_tag_i;
    logic [4:0]   fld_t_size_i;
    logic [255:0] fld_val_i;
    logic [7:0]   fld_v_size_i;
    logic         fld_full_o;
    logic         send_i;
    logic         busy_o;
    logic         msg_done_o;
    logic         tag_valid_o;
    logic         val_valid_o;
    logic         checksum_o;
    logic [31:0]  tag_o;
    logic [4:0]   t_size_o;
    logic [255:0] val_o;
    logic [7:0]   v_size_o;
    logic         ser_done_i;
    logic [7:0]   ser_data_i;
    logic         ser_data_valid_i;
    logic [7:0]   cksum_o;

    int vectors = 0;
    int miscompares = 0;

    fix_msg_sequencer dut (
        .clk(clk), .rst(rst),
        .fld_wr_i(fld_wr_i), .fld_tag_i(fld_tag_i), .fld_t_size_i(fld_t_size_i),
        .fld_val_i(fld_val_i), .fld_v_size_i(fld_v_size_i), .fld_full_o(fld_full_o),
        .send_i(send_i), .busy_o(busy_o), .msg_done_o(msg_done_o),
        .tag_valid_o(tag_valid_o), .val_valid_o(val_valid_o), .checksum_o(checksum_o),
        .tag_o(tag_o), .t_size_o(t_size_o), .val_o(val_o), .v_size_o(v_size_o),
        .ser_done_i(ser_done_i), .ser_data_i(ser_data_i), .ser_data_valid_i(ser_data_valid_i),
        .cksum_o(cksum_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_field(input logic [31:0] tg, input logic [4:0] ts, input logic [255:0] v, input logic [7:0] vs);
        fld_wr_i = 1'b1; fld_tag_i = tg; fld_t_size_i = ts; fld_val_i = v; fld_v_size_i = vs;
        tick();
        fld_wr_i = 1'b0;
    endtask

    task automatic send();
        send_i = 1'b1;
        tick();
        send_i = 1'b0;
    endtask

    // Serializer model: n payload bytes then a terminator byte with done.
    task automatic emit(input logic [255:0] d, input int n, input logic [7:0] term);
        for (int i = 0; i < n; i++) begin
            ser_data_valid_i = 1'b1; ser_data_i = d[i*8 +: 8];
            tick();
        end
        ser_data_i = term; ser_done_i = 1'b1;
        tick();
        ser_done_i = 1'b0; ser_data_valid_i = 1'b0; ser_data_i = 8'd0;
    endtask

    task automatic serve_msg(input int stall, output int ntag, output int nval, output int ndone,
                             output logic [31:0] ck_tag, output logic [23:0] ck_val);
        int cyc;
        bit stalled;
        logic [31:0] snap;
        cyc = 0; stalled = 1'b0; ntag = 0; nval = 0; ndone = 0; ck_tag = '0; ck_val = '0;
        while (ndone == 0 && cyc < 3000) begin
            if (msg_done_o) begin
                ndone = 1;
            end else if (tag_valid_o) begin
                if (checksum_o) ck_tag = tag_o; else ntag++;
                if (!stalled && stall > 0) begin
                    stalled = 1'b1; snap = tag_o;
                    for (int s = 0; s < stall; s++) begin
                        tick(); cyc++;
                        vectors++;
                        if (tag_valid_o !== 1'b1 || tag_o !== snap) begin
                            miscompares++;
                            $display("FAIL stall_hold cycle %0d: tag_valid=%b tag=%h expected 1 %h", s, tag_valid_o, tag_o, snap);
                        end
                    end
                end
                cyc += int'(t_size_o) + 1;
                emit({224'd0, tag_o}, int'(t_size_o), 8'h3d);
            end else if (val_valid_o) begin
                if (checksum_o) ck_val = val_o[23:0]; else nval++;
                cyc += int'(v_size_o) + 1;
                emit(val_o, int'(v_size_o), 8'h01);
            end else begin
                tick(); cyc++;
            end
        end
        vectors++;
        if (ndone == 0) begin
            miscompares++;
            $display("FAIL msg_timeout: got no msg_done_o within %0d cycles, expected one", cyc);
        end
    endtask

    task automatic check_msg(input string nm, input int ntag, input int nval, input logic [23:0] ck_val,
                             input logic [31:0] ck_tag, input int exp_n, input logic [7:0] exp_ck, input logic [23:0] exp_val);
        vectors++;
        if (ntag !== exp_n || nval !== exp_n) begin
            miscompares++;
            $display("FAIL %s_handshakes: tag=%0d val=%0d expected %0d", nm, ntag, nval, exp_n);
        end
        vectors++;
        if (cksum_o !== exp_ck) begin
            miscompares++;
            $display("FAIL %s_cksum: got %h expected %h", nm, cksum_o, exp_ck);
        end
        vectors++;
        if (ck_val !== exp_val || ck_tag !== 32'h0000_3031) begin
            miscompares++;
            $display("FAIL %s_trailer: tag %h val %h expected 00003031 %h", nm, ck_tag, ck_val, exp_val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if ({busy_o, msg_done_o, tag_valid_o, val_valid_o, checksum_o, fld_full_o} !== 6'b0 ||
            tag_o !== 32'd0 || val_o !== 256'd0 || cksum_o !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b tv=%b vv=%b ck=%b full=%b tag=%h cksum=%h expected all 0",
                     busy_o, msg_done_o, tag_valid_o, val_valid_o, checksum_o, fld_full_o, tag_o, cksum_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_one_field();
        int nt, nv, nd; logic [31:0] ct; logic [23:0] cv;
        wr_field(32'h38, 5'd1, 256'h41, 8'd1);
        send();
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL one_busy: got %b expected 1", busy_o);
        end
        serve_msg(0, nt, nv, nd, ct, cv);
        check_msg("one", nt, nv, cv, ct, 1, 8'hB7, 24'h333831);
        tick();
        vectors++;
        if (busy_o !== 1'b0 || msg_done_o !== 1'b0 || checksum_o !== 1'b0) begin
            miscompares++;
            $display("FAIL one_after_done: busy=%b done=%b ck=%b expected 0 0 0", busy_o, msg_done_o, checksum_o);
        end
    endtask

    task automatic test_wrap();
        int nt, nv, nd; logic [31:0] ct; logic [23:0] cv;
        wr_field(32'h35, 5'd1, 256'h6d6d, 8'd2);
        wr_field(32'h35, 5'd1, 256'h6d6d, 8'd2);
        wr_field(32'h35, 5'd1, 256'h6e6d, 8'd2);
        send();
        serve_msg(0, nt, nv, nd, ct, cv);
        check_msg("wrap", nt, nv, cv, ct, 3, 8'hE8, 24'h323332);
        tick();
    endtask

    task automatic test_fill();
        int nt, nv, nd; logic [31:0] ct; logic [23:0] cv;
        for (int i = 0; i < 16; i++) wr_field(32'h31, 5'd1, 256'h30, 8'd1);
        vectors++;
        if (fld_full_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: got %b expected 1", fld_full_o);
        end
        wr_field(32'h39, 5'd1, 256'h39, 8'd1);
        send();
        serve_msg(0, nt, nv, nd, ct, cv);
        check_msg("fill", nt, nv, cv, ct, 16, 8'hF0, 24'h303432);
        tick();
        vectors++;
        if (fld_full_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_drained: full=%b expected 0", fld_full_o);
        end
    endtask

    task automatic test_empty_and_busy();
        int nt, nv, nd; logic [31:0] ct; logic [23:0] cv;
        logic seen;
        seen = 1'b0;
        send();
        for (int i = 0; i < 5; i++) begin
            seen |= busy_o | tag_valid_o | msg_done_o;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_send: activity=%b expected 0", seen);
        end
        wr_field(32'h38, 5'd1, 256'h41, 8'd1);
        send();
        tick();
        send();
        tick();
        send();
        serve_msg(0, nt, nv, nd, ct, cv);
        check_msg("busy_send", nt, nv, cv, ct, 1, 8'hB7, 24'h333831);
        seen = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            seen |= busy_o | tag_valid_o | msg_done_o;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_send_single: second message activity=%b expected 0", seen);
        end
    endtask

    task automatic test_stall();
        int nt, nv, nd; logic [31:0] ct; logic [23:0] cv;
        wr_field(32'h39, 5'd1, 256'h5a, 8'd1);
        send();
        serve_msg(20, nt, nv, nd, ct, cv);
        check_msg("stall", nt, nv, cv, ct, 1, 8'hD1, 24'h393032);
        tick();
        ser_done_i = 1'b1; ser_data_valid_i = 1'b1; ser_data_i = 8'hff;
        tick();
        ser_done_i = 1'b0; ser_data_valid_i = 1'b0; ser_data_i = 8'd0;
        tick();
        vectors++;
        if (busy_o !== 1'b0 || tag_valid_o !== 1'b0 || val_valid_o !== 1'b0 || cksum_o !== 8'hD1) begin
            miscompares++;
            $display("FAIL stray_done: busy=%b tv=%b vv=%b cksum=%h expected 0 0 0 d1",
                     busy_o, tag_valid_o, val_valid_o, cksum_o);
        end
    endtask

    task automatic test_reset_mid();
        int nt, nv, nd; logic [31:0] ct; logic [23:0] cv;
        int vcnt, cyc;
        for (int i = 0; i < 4; i++) wr_field(32'h38, 5'd1, 256'h41, 8'd1);
        send();
        vcnt = 0; cyc = 0;
        while (vcnt < 2 && cyc < 500) begin
            if (tag_valid_o) begin
                cyc += 2; emit({224'd0, tag_o}, int'(t_size_o), 8'h3d);
            end else if (val_valid_o) begin
                vcnt++;
                if (vcnt < 2) begin
                    cyc += 2; emit(val_o, int'(v_size_o), 8'h01);
                end
            end else begin
                tick(); cyc++;
            end
        end
        vectors++;
        if (val_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reach_val2: val_valid=%b expected 1", val_valid_o);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy_o, msg_done_o, tag_valid_o, val_valid_o, checksum_o, fld_full_o} !== 6'b0 ||
            tag_o !== 32'd0 || val_o !== 256'd0 || cksum_o !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_async_reset: busy=%b done=%b tv=%b vv=%b ck=%b full=%b tag=%h cksum=%h expected all 0",
                     busy_o, msg_done_o, tag_valid_o, val_valid_o, checksum_o, fld_full_o, tag_o, cksum_o);
        end
        tick();
        rst = 1'b0;
        tick();
        send();
        tick();
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_queue_flushed: busy=%b expected 0", busy_o);
        end
        wr_field(32'h39, 5'd1, 256'h5a, 8'd1);
        send();
        serve_msg(0, nt, nv, nd, ct, cv);
        check_msg("mid_restart", nt, nv, cv, ct, 1, 8'hD1, 24'h393032);
        tick();
    endtask

    initial begin
        rst = 1'b1; fld_wr_i = 1'b0; fld_tag_i = '0; fld_t_size_i = '0; fld_val_i = '0; fld_v_size_i = '0;
        send_i = 1'b0; ser_done_i = 1'b0; ser_data_i = 8'd0; ser_data_valid_i = 1'b0;
        test_reset();
        test_one_field();
        test_wrap();
        test_fill();
        test_empty_and_busy();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
